// File: rtl/usart_rx_frame_if.sv
// rtl/usart_rx_frame_if.sv - host-side byte handshake of the framed serial receiver
interface usart_rx_frame_if;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output dout,
        output valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  dout,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/usart_rx_frame.sv
// rtl/usart_rx_frame.sv - oversampled framed async serial receiver (start, data LSB first, parity, stop)
module usart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_data,
    usart_rx_frame_if.master  host,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);
    localparam logic          ODD_SENSE   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_pend;
    logic                   tick;
    logic                   handshake;

    assign tick      = (cnt == '0);
    assign handshake = host.valid && host.ready;

    // Line is idle-high, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            shreg           <= '0;
            par_pend        <= 1'b0;
            busy            <= 1'b0;
            host.dout       <= '0;
            host.valid      <= 1'b0;
            host.parity_err <= 1'b0;
            host.frame_err  <= 1'b0;
            host.overrun    <= 1'b0;
        end else begin
            // A handshake retires the held byte; a frame delivered this same cycle overrides below.
            if (handshake) begin
                host.valid   <= 1'b0;
                host.overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_RELOAD;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt      <= BIT_RELOAD;
                            idx      <= '0;
                            par_pend <= 1'b0;
                            state    <= DATA;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                DATA: begin
                    if (tick) begin
                        shreg[idx] <= rx_s;
                        cnt        <= BIT_RELOAD;
                        if (idx == LAST_BIT) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                PARITY: begin
                    if (tick) begin
                        par_pend <= (rx_s != ((^shreg) ^ ODD_SENSE));
                        cnt      <= BIT_RELOAD;
                        state    <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (!host.valid || host.ready) begin
                            host.dout       <= 8'(shreg);
                            host.parity_err <= par_pend;
                            host.frame_err  <= !rx_s;
                            host.valid      <= 1'b1;
                        end else begin
                            host.overrun <= 1'b1;
                        end
                        // A low stop bit may be a break; hold off until the line recovers.
                        state <= rx_s ? IDLE : WAIT_IDLE;
                        busy  <= !rx_s;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usart_rx_frame.sv
// tb/tb_usart_rx_frame.sv - scoreboard bench for usart_rx_frame with directed and random frames
module tb_usart_rx_frame;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_data = 1'b1;
    logic busy;

    usart_rx_frame_if bus();

    usart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .PARITY_EN(1),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .host(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    // Monitor: every accepted byte must match the oldest expected entry.
    exp_t mon_act;
    exp_t mon_exp;
    always @(negedge clk) begin
        if (reset && bus.valid && bus.ready) begin
            mon_act = {bus.dout, bus.parity_err, bus.frame_err, bus.overrun};
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual=%0h expected=none", mon_act);
            end else begin
                mon_exp = q.pop_front();
                check("handshake", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    // mode: 0 plain, 1 delivery-latency check, 2 ready pulse on stop sample, 3 reset during data bit 4
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int stop_low,
                              input int mode, input int gap);
        logic bits [10];
        logic par;
        par = logic'($countones(d) % 2) ^ bad_par;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9] = par;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 rx_data = bits[i];
            if (mode == 3 && i == 5) begin
                repeat (5) @(posedge clk);
                #1 reset = 1'b0;
                #1 check("async_reset_outputs",
                         {bus.dout, bus.valid, bus.parity_err, bus.frame_err, bus.overrun, busy}, 0);
                repeat (2) @(posedge clk);
                #1 rx_data = 1'b1;
                reset = 1'b1;
                repeat (4) @(posedge clk);
                return;
            end
            repeat (CPB) @(posedge clk);
        end
        #1 rx_data = (stop_low > 0) ? 1'b0 : 1'b1;
        repeat (10) @(posedge clk);
        #1;
        if (mode == 1) check("valid_before_stop_sample", bus.valid, 0);
        if (mode == 2) bus.ready = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 1) check("valid_after_stop_sample", bus.valid, 1);
        if (mode == 2) bus.ready = 1'b0;
        if (stop_low > 0) begin
            repeat (stop_low - 11) @(posedge clk);
            #1 check("busy_while_line_low", busy, 1);
            rx_data = 1'b1;
        end else begin
            @(posedge clk);
            #1;
            if (mode == 1) check("valid_cleared_after_accept", bus.valid, 0);
            repeat (4) @(posedge clk);
        end
        repeat (2 + gap) @(posedge clk);
    endtask

    task automatic send_expect(input logic [7:0] d, input bit bad_par, input int stop_low,
                               input int mode, input int gap, input bit ovr);
        q.push_back({d, logic'(bad_par), logic'(stop_low > 0), logic'(ovr)});
        send_frame(d, bad_par, stop_low, mode, gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=%0d checks expected=finish", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs",
                 {bus.dout, bus.valid, bus.parity_err, bus.frame_err, bus.overrun, busy}, 0);
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Nominal frame with latency probe.
        send_expect(8'hA5, 0, 0, 1, 3, 0);

        // Start-bit glitch shorter than half a bit.
        @(posedge clk);
        #1 rx_data = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("glitch_busy_high", busy, 1);
        @(posedge clk);
        #1 rx_data = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("glitch_busy_low", busy, 0);
        check("glitch_no_valid", bus.valid, 0);
        repeat (5) @(posedge clk);

        // Parity error, then break-length framing error, then a clean frame.
        send_expect(8'h3C, 1, 0, 0, 2, 0);
        send_expect(8'h3C, 0, 40, 0, 2, 0);
        send_expect(8'h81, 0, 0, 0, 2, 0);

        // Overrun: second frame dropped while the first is unaccepted.
        bus.ready = 1'b0;
        send_expect(8'h11, 0, 0, 0, 2, 1);
        send_frame(8'h22, 0, 0, 0, 2);
        check("overrun_set", bus.overrun, 1);
        check("overrun_dout_kept", bus.dout, 8'h11);
        @(posedge clk);
        #1 bus.ready = 1'b1;
        @(posedge clk);
        #1 bus.ready = 1'b0;
        check("overrun_valid_cleared", bus.valid, 0);
        check("overrun_cleared", bus.overrun, 0);

        // Handshake coinciding with the next frame's stop sample.
        send_expect(8'h55, 0, 0, 0, 2, 0);
        send_expect(8'h66, 0, 0, 2, 2, 0);
        check("coincide_valid_held", bus.valid, 1);
        check("coincide_dout", bus.dout, 8'h66);
        check("coincide_no_overrun", bus.overrun, 0);
        @(posedge clk);
        #1 bus.ready = 1'b1;
        @(posedge clk);
        #1 check("coincide_valid_cleared", bus.valid, 0);

        // Reset mid-frame, then a clean frame.
        send_frame(8'hF0, 0, 0, 3, 0);
        send_expect(8'h0F, 0, 0, 0, 2, 0);

        // Random frames against a randomly stalling host.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [7:0] d;
                    bit bad;
                    int sl;
                    d   = 8'($urandom);
                    bad = ($urandom_range(0, 7) == 0);
                    sl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 40)) : 0;
                    send_expect(d, bad, sl, 0, int'($urandom_range(0, 10)), 0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        bus.ready = 1'b1;
        for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #1 check("queue_drained", q.size(), 0);
        check("final_valid_low", bus.valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
